// File: rtl/fp_div_pkg.sv
// Shared types and constants for the binary32 divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StDivide,
        StRound
    } state_e;

    // Special-case outcome decided while unpacking, applied when rounding.
    typedef enum logic [2:0] {
        SpNone,
        SpNan,
        SpDivZero,
        SpInf,
        SpZero
    } special_e;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned QBITS = 27;

    localparam int unsigned FlagInvalid   = 4;
    localparam int unsigned FlagDivZero   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    localparam logic [31:0] CanonNan = 32'h7FC0_0000;

endpackage

// File: rtl/fp_div_round.sv
// Round-to-nearest-even, range check and special-case override for the quotient.
module fp_div_round
    import fp_div_pkg::*;
(
    input  logic [QBITS-1:0] quo_i,
    input  logic             rem_nz_i,
    input  logic signed [9:0] exp_i,
    input  logic             sign_i,
    input  special_e         special_i,
    output logic [31:0]      result_o,
    output logic [4:0]       flags_o
);

    logic [23:0]       mant;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              inc;
    logic [24:0]       sum;
    logic signed [9:0] exp_f;
    logic [22:0]       frac;

    // Select mantissa/GRS by the quotient's leading bit, round, then classify.
    always_comb begin
        if (quo_i[QBITS-1]) begin
            mant   = quo_i[26:3];
            guard  = quo_i[2];
            rnd    = quo_i[1];
            sticky = quo_i[0] | rem_nz_i;
        end else begin
            mant   = quo_i[25:2];
            guard  = quo_i[1];
            rnd    = quo_i[0];
            sticky = rem_nz_i;
        end
        inc   = guard & (rnd | sticky | mant[0]);
        sum   = {1'b0, mant} + {24'd0, inc};
        exp_f = exp_i + {9'd0, sum[24]};
        // A carry-out leaves 1.000..., so the shifted fraction is all zero.
        frac  = sum[24] ? sum[23:1] : sum[22:0];

        result_o = '0;
        flags_o  = '0;
        case (special_i)
            SpNan: begin
                result_o             = CanonNan;
                flags_o[FlagInvalid] = 1'b1;
            end
            SpDivZero: begin
                result_o             = {sign_i, 8'hFF, 23'd0};
                flags_o[FlagDivZero] = 1'b1;
            end
            SpInf:  result_o = {sign_i, 8'hFF, 23'd0};
            SpZero: result_o = {sign_i, 31'd0};
            default: begin
                if (exp_f >= 10'sd255) begin
                    result_o              = {sign_i, 8'hFF, 23'd0};
                    flags_o[FlagOverflow] = 1'b1;
                    flags_o[FlagInexact]  = 1'b1;
                end else if (exp_f <= 10'sd0) begin
                    result_o               = {sign_i, 31'd0};
                    flags_o[FlagUnderflow] = 1'b1;
                    flags_o[FlagInexact]   = 1'b1;
                end else begin
                    result_o             = {sign_i, exp_f[7:0], frac};
                    flags_o[FlagInexact] = guard | rnd | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_div.sv
// Fixed-latency binary32 divider: unpack, 27-step restoring divide, round.
module fp_div
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       rem_q, rem_d;
    logic [QBITS-1:0]  quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    special_e          special_q, special_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic [4:0]        flags_q, flags_d;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0] ma, mb;
    logic [24:0] diff;
    logic        qbit;
    logic [31:0] rnd_result;
    logic [4:0]  rnd_flags;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    // Denormals flush to zero: no hidden bit when the exponent field is zero.
    assign ma     = a_zero ? 24'd0 : {1'b1, fa};
    assign mb     = b_zero ? 24'd0 : {1'b1, fb};

    fp_div_round u_round (
        .quo_i     (quo_q),
        .rem_nz_i  (rem_q != 25'd0),
        .exp_i     (exp_q),
        .sign_i    (sign_q),
        .special_i (special_q),
        .result_o  (rnd_result),
        .flags_o   (rnd_flags)
    );

    // Next-state and datapath updates for each FSM phase.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mb_d      = mb_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        special_d = special_q;
        done_d    = 1'b0;
        result_d  = result_q;
        flags_d   = flags_q;
        diff      = rem_q;
        qbit      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                rem_d  = {1'b0, ma};
                mb_d   = mb;
                quo_d  = '0;
                cnt_d  = '0;
                sign_d = a_q[31] ^ b_q[31];
                // Pre-adjust so the quotient lands in [1,2) or is shifted one place.
                exp_d  = $signed({2'b00, ea} - {2'b00, eb} + 10'(BIAS) - {9'd0, (ma < mb)});
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    special_d = SpNan;
                end else if (b_zero) begin
                    special_d = SpDivZero;
                end else if (a_inf) begin
                    special_d = SpInf;
                end else if (b_inf || a_zero) begin
                    special_d = SpZero;
                end else begin
                    special_d = SpNone;
                end
                state_d = StDivide;
            end
            StDivide: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    diff = rem_q - {1'b0, mb_q};
                    qbit = 1'b1;
                end
                rem_d = diff << 1;
                quo_d = {quo_q[QBITS-2:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(QBITS - 1)) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                result_d = rnd_result;
                flags_d  = rnd_flags;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            special_q <= SpNone;
            done_q    <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mb_q      <= mb_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            done_q    <= done_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: fixed vectors, busy/back-to-back and reset-abort cases.
module tb_fp_div;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    fp_div dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int bad    = 0;
    int n_done = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    localparam int NVEC = 17;
    logic [31:0] tv_a   [NVEC] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                                   32'h7F7FFFFF, 32'h00800000, 32'hC0C00000, 32'h7F800000,
                                   32'h40400000, 32'h7FC00001, 32'h80000000, 32'h7F800000,
                                   32'h3F800000, 32'hBF800000, 32'h00400000, 32'h40000000,
                                   32'h3F800000};
    logic [31:0] tv_b   [NVEC] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                   32'h3F000000, 32'h4B000000, 32'h40000000, 32'h40000000,
                                   32'hFF800000, 32'h3F800000, 32'h40A00000, 32'hFF800000,
                                   32'h3F800000, 32'h80000000, 32'h3F800000, 32'h40400000,
                                   32'h41200000};
    logic [31:0] tv_res [NVEC] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
                                   32'h7F800000, 32'h00000000, 32'hC0400000, 32'h7F800000,
                                   32'h80000000, 32'h7FC00000, 32'h80000000, 32'h7FC00000,
                                   32'h3F800000, 32'h7F800000, 32'h00000000, 32'h3F2AAAAB,
                                   32'h3DCCCCCD};
    logic [4:0]  tv_flg [NVEC] = '{5'b00000, 5'b00001, 5'b01000, 5'b10000,
                                   5'b00101, 5'b00011, 5'b00000, 5'b00000,
                                   5'b00000, 5'b10000, 5'b00000, 5'b10000,
                                   5'b00000, 5'b01000, 5'b00000, 5'b00001,
                                   5'b00001};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Drive one request from a negedge; the expectation is queued once the edge samples it.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] res, input logic [4:0] flg);
        exp_t e;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res = res;
        e.flg = flg;
        e.cyc = cyc;
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check_val("drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    // Every done must match the oldest outstanding expectation and arrive 29 edges on.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_val("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("result", result, mon_e.res);
                check_val("flags", {27'd0, flags}, {27'd0, mon_e.flg});
                check_val("latency", cyc - mon_e.cyc, 32'd29);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd0;

        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_flags", {27'd0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            issue(tv_a[i], tv_b[i], tv_res[i], tv_flg[i]);
            wait_drain();
        end

        // A second start while busy must be dropped.
        nd0 = n_done;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        repeat (5) @(negedge clk);
        check_val("busy_mid", {31'd0, busy}, 32'd1);
        a     = 32'h3F800000;
        b     = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        check_val("one_done", n_done - nd0, 32'd1);

        // Start raised in the done cycle is taken on the following edge.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check_val("b2b_done_seen", {31'd0, done}, 32'd1);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
        wait_drain();

        // Reset during DIVIDE cycle 10 clears outputs and suppresses done.
        issue(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001);
        repeat (10) @(posedge clk);
        #2;
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_result", result, 32'd0);
        check_val("abort_flags", {27'd0, flags}, 32'd0);
        sb.delete();
        nd0 = n_done;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_val("no_done_after_rst", n_done - nd0, 32'd0);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
